// File: rtl/shifter_pkg.sv
// Shared constants for the iterative shift unit: operation codes and FSM states.
package shifter_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_stage.sv
// Combinational shift step: limits the remaining amount to STEP and shifts
// the accumulator by that many positions according to the operation code.
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [1:0]       i_mode,
  input  logic [SHW-1:0]   i_rem,
  output logic [WIDTH-1:0] o_acc,
  output logic [SHW-1:0]   o_n
);

  logic [31:0] w_n32;

  // Step size for this cycle: min(STEP, remaining amount).
  // When STEP >= WIDTH the first branch can never be taken, since rem <= WIDTH-1.
  always_comb begin
    o_n = i_rem;
    if (32'(i_rem) > 32'(STEP)) begin
      o_n = SHW'(STEP);
    end
  end

  assign w_n32 = 32'(o_n);

  // Apply the selected shift; SRA replicates the current MSB, ROR wraps bit 0 to the MSB.
  always_comb begin
    o_acc = i_acc;
    case (i_mode)
      SH_SLL:  o_acc = i_acc << w_n32;
      SH_SRL:  o_acc = i_acc >> w_n32;
      SH_SRA:  o_acc = $unsigned($signed(i_acc) >>> w_n32);
      SH_ROR:  o_acc = (i_acc >> w_n32) | (i_acc << (32'(WIDTH) - w_n32));
      default: o_acc = i_acc;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit: captures an operand on start, shifts up to STEP
// positions per clock until the amount is consumed, then pulses done.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  state_e             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHW-1:0]     r_rem;
  logic [1:0]         r_mode;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_dout;

  logic [WIDTH-1:0]   w_acc_nxt;
  logic [SHW-1:0]     w_n;

  shift_stage #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_stage (
    .i_acc  (r_acc),
    .i_mode (r_mode),
    .i_rem  (r_rem),
    .o_acc  (w_acc_nxt),
    .o_n    (w_n)
  );

  // Control FSM with rem counter and registered busy/done/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_mode  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc   <= data;
            r_rem   <= shamt;
            r_mode  <= mode;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_rem != '0) begin
            r_acc <= w_acc_nxt;
            r_rem <= r_rem - w_n;
          end else begin
            r_dout  <= r_acc;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign dataOut = r_dout;

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboard bench for iterative_shifter: one STEP=1 and one STEP=4 instance.
module tb_iterative_shifter;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  typedef struct {
    logic [31:0] val;
    int          done_cyc;
    int          lat;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start1, start4;
  logic [1:0]  mode;
  logic [4:0]  shamt;
  logic [31:0] data;
  logic        busy1, done1, busy4, done4;
  logic [31:0] dout1, dout4;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   bc1 = 0;
  int   bc4 = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  iterative_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .shamt(shamt),
    .data(data), .busy(busy1), .done(done1), .dataOut(dout1)
  );

  iterative_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .shamt(shamt),
    .data(data), .busy(busy4), .done(done4), .dataOut(dout4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Monitor for the STEP=1 instance.
  always @(posedge clk) begin
    #1;
    if (rst) bc1 = 0;
    else if (done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s1 unexpected done: got done with dataOut=%0h, required no done", dout1);
      end else begin
        e1 = q1.pop_front();
        chk({e1.name, " data"}, dout1, e1.val);
        chk({e1.name, " done edge"}, cyc, e1.done_cyc);
        chk({e1.name, " busy cycles"}, bc1, e1.lat);
      end
      bc1 = 0;
    end else if (busy1) bc1++;
  end

  // Monitor for the STEP=4 instance.
  always @(posedge clk) begin
    #1;
    if (rst) bc4 = 0;
    else if (done4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s4 unexpected done: got done with dataOut=%0h, required no done", dout4);
      end else begin
        e4 = q4.pop_front();
        chk({e4.name, " data"}, dout4, e4.val);
        chk({e4.name, " done edge"}, cyc, e4.done_cyc);
        chk({e4.name, " busy cycles"}, bc4, e4.lat);
      end
      bc4 = 0;
    end else if (busy4) bc4++;
  end

  // Drive one request on instance d (1 or 4) from a negedge; expected result is pushed at issue.
  task automatic issue(input int d, input logic [1:0] m, input logic [4:0] s,
                       input logic [31:0] x, input logic [31:0] e, input int lat,
                       input bit nowait, input bit push, input string nm);
    if (!nowait) begin
      for (int i = 0; i < 300; i++) begin
        if (!((d == 1) ? busy1 : busy4)) break;
        @(negedge clk);
      end
      if ((d == 1) ? busy1 : busy4) begin
        checks++;
        errors++;
        $display("FAIL %s idle wait: got busy=1 after 300 cycles, required busy=0", nm);
      end
    end
    mode  = m;
    shamt = s;
    data  = x;
    if (d == 1) start1 = 1'b1;
    else        start4 = 1'b1;
    if (push) begin
      if (d == 1) q1.push_back('{e, cyc + 1 + lat, lat, nm});
      else        q4.push_back('{e, cyc + 1 + lat, lat, nm});
    end
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    mode   = 2'($urandom);
    shamt  = 5'($urandom);
    data   = $urandom;
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    mode = '0; shamt = '0; data = '0;
    repeat (2) @(negedge clk);
    chk("reset busy s1", 32'(busy1), 32'd0);
    chk("reset done s1", 32'(done1), 32'd0);
    chk("reset dataOut s1", dout1, 32'h0);
    chk("reset busy s4", 32'(busy4), 32'd0);
    chk("reset done s4", 32'(done4), 32'd0);
    chk("reset dataOut s4", dout4, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // STEP=1 directed vectors
    issue(1, M_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001, 32, 0, 1, "s1 srl31");
    issue(1, M_SRA, 5'd4,  32'h8000_0000, 32'hF800_0000, 5,  0, 1, "s1 sra4");
    issue(1, M_SLL, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 32, 0, 1, "s1 sll31");
    issue(1, M_ROR, 5'd1,  32'h0000_0001, 32'h8000_0000, 2,  0, 1, "s1 ror1");
    issue(1, M_SRL, 5'd0,  32'h1234_5678, 32'h1234_5678, 1,  0, 1, "s1 shamt0");

    // Second start while busy must be ignored
    issue(1, M_SLL, 5'd2, 32'h0000_0003, 32'h0000_000C, 3, 0, 1, "s1 ignore");
    mode = M_SRL; shamt = 5'd1; data = 32'h0000_FFFF; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;

    // Start asserted in the done cycle is accepted immediately
    issue(1, M_SRA, 5'd8, 32'hF000_0000, 32'hFFF0_0000, 9, 0, 1, "s1 b2b first");
    for (int i = 0; i < 100; i++) begin
      if (done1) break;
      @(negedge clk);
    end
    issue(1, M_ROR, 5'd8, 32'h1234_5678, 32'h7812_3456, 9, 1, 1, "s1 b2b second");

    // Reset in the middle of an operation: aborted op never completes
    issue(1, M_SLL, 5'd20, 32'h0000_0001, 32'h0, 0, 0, 0, "s1 aborted");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 32'(busy1), 32'd0);
    chk("midrst done", 32'(done1), 32'd0);
    chk("midrst dataOut", dout1, 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(1, M_SRL, 5'd4, 32'h0000_00F0, 32'h0000_000F, 5, 0, 1, "s1 after rst");

    // STEP=4 directed vectors
    issue(4, M_SLL, 5'd5,  32'h0000_0001, 32'h0000_0020, 3, 0, 1, "s4 sll5");
    issue(4, M_ROR, 5'd4,  32'h0000_000F, 32'hF000_0000, 2, 0, 1, "s4 ror4");
    issue(4, M_SRA, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 9, 0, 1, "s4 sra31");
    issue(4, M_SRL, 5'd7,  32'hDEAD_BEEF, 32'h01BD_5B7D, 3, 0, 1, "s4 srl7");
    issue(4, M_ROR, 5'd6,  32'h0000_0081, 32'h0400_0002, 3, 0, 1, "s4 ror6");

    for (int i = 0; i < 300; i++) begin
      if (q1.size() == 0 && q4.size() == 0) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("pending results", 32'(q1.size() + q4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Multi-cycle, parametrised shift unit for the ALU/EX path. Shifts up to STEP bit positions per clock until the requested shift amount has been consumed.
- Supports SLL, SRL, SRA and ROR; the existing single-step shifter supports only a 1-bit logical right shift.
- Replaces the chained 1-bit shift stages with one registered datapath and a start/busy/done handshake, so the pipeline controller can stall EX while busy is high.

Parameters:
- WIDTH, 32, data word width in bits; must be a power of 2 and at least 2.
- STEP, 1, maximum bit positions shifted per cycle; must be a power of 2 with 1 <= STEP <= WIDTH.
- SHW, $clog2(WIDTH), localparam; width of the shift amount.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- shamt  input  SHW  shift amount, 0..WIDTH-1.
- data  input  WIDTH  operand.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; dataOut is valid from this cycle.
- dataOut  output  WIDTH  result register.

Behaviour:
- Reset: synchronous and active-high. On a rising edge with rst=1:
  - state=IDLE;
  - busy=0, done=0, dataOut=0;
  - internal acc, rem and mode registers cleared.
  - rst overrides start and any operation in progress. An aborted operation never produces done.
- States: IDLE and SHIFT. busy is high exactly when state=SHIFT.
- IDLE, start=1:
  - capture acc<=data, rem<=shamt, modeReg<=mode;
  - move to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT, rem!=0:
  - n = min(STEP, rem);
  - acc <= acc shifted by n per modeReg; rem <= rem-n.
- SHIFT, rem==0:
  - dataOut<=acc, done<=1;
  - move to IDLE.
- done is driven low on every other edge, so it is a single-cycle pulse.
- Shift semantics:
  - SLL fills with 0 from the LSB.
  - SRL fills with 0 from the MSB.
  - SRA fills with the sign bit (acc[WIDTH-1]) of the current acc value.
  - ROR rotates: bits leaving bit 0 re-enter at bit WIDTH-1.
- Latency: done rises ceil(shamt/STEP)+1 edges after the edge that accepts start. shamt=0 gives 1 cycle and dataOut=data.
- start while busy=1 is ignored and not queued.
- start in the cycle done=1 (state=IDLE) is accepted; back-to-back throughput is allowed.
- data, shamt and mode are don't-care except in the accepting cycle. Later changes do not affect the operation in progress.
- dataOut holds the last result until the next done or rst.
- shamt is SHW bits wide, so an amount of WIDTH or more cannot be expressed. Callers mask the amount to SHW bits.

Decomposition:
- Package shifter_pkg holds:
  - mode constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11;
  - state encodings ST_IDLE and ST_SHIFT.
- One combinational sub-module, shift_stage (parameters WIDTH, STEP), computes the shift of acc by n in 0..STEP for the given mode.
- The FSM, rem counter and output registers stay in iterative_shifter.

Test Plan:
- WIDTH=32, STEP=1: SRL of 0x80000000 by 31 -> busy high 32 cycles, done on edge 32 after accept, dataOut=0x00000001.
- STEP=1: SRA of 0x80000000 by 4 -> dataOut=0xF8000000 at latency 5; SLL of 0xFFFFFFFF by 31 -> 0x80000000.
- STEP=1: ROR of 0x00000001 by 1 -> 0x80000000; shamt=0 with data=0x12345678 -> done after 1 cycle, dataOut=0x12345678.
- STEP=4:
  - SLL of 0x00000001 by 5 -> latency 3, dataOut=0x00000020;
  - ROR of 0x0000000F by 4 -> latency 2, 0xF0000000.
- Handshake:
  - a second start with different data during busy is ignored; only one done is produced, carrying the first result;
  - start asserted in the done cycle -> new operation accepted, next done correct.
- Reset mid-operation: rst during SHIFT -> next edge busy=0, dataOut=0, and no done follows; a subsequent start operates normally.
